// File: rtl/hazard_pkg.sv
// Shared types and defaults for the hazard scoreboard: in-flight entry layout,
// forwarding-select type and default pipeline geometry.
package hazard_pkg;

    localparam int DEF_DEPTH    = 3;
    localparam int DEF_LOAD_LAT = 1;
    localparam int RD_W         = 5;
    // rdy must hold any stage index up to the maximum depth of 8
    localparam int RDY_W        = 3;

    typedef struct packed {
        logic             valid;
        logic [RD_W-1:0]  rd;
        logic [RDY_W-1:0] rdy;
    } inflight_t;

    typedef logic [$clog2(DEF_DEPTH)-1:0] fwd_sel_t;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Stall and flush event counters for the hazard scoreboard; both wrap modulo 2^32.
module hazard_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_inc,
    input  logic        flush_inc,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    logic [31:0] stall_cnt_reg;
    logic [31:0] flush_cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (stall_inc) stall_cnt_reg <= stall_cnt_reg + 32'd1;
            if (flush_inc) flush_cnt_reg <= flush_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard controller: tracks in-flight writes EX..WB and derives stalls,
// flushes and forwarding selects. Counters exist only with HAZARD_PERF_CNT_EN.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG     = 32,
    parameter int RA_W     = $clog2(NREG),
    parameter int DEPTH    = DEF_DEPTH,
    parameter int LOAD_LAT = DEF_LOAD_LAT,
    parameter int SEL_W    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid_i,
    input  logic [RA_W-1:0]  dec_rs1_i,
    input  logic [RA_W-1:0]  dec_rs2_i,
    input  logic             dec_use_rs1_i,
    input  logic             dec_use_rs2_i,
    input  logic [RA_W-1:0]  dec_rd_i,
    input  logic             dec_wen_i,
    input  logic             dec_load_i,
    input  logic             redirect_i,
    input  logic             ex_busy_i,
    output logic             stall_f_o,
    output logic             stall_d_o,
    output logic             stall_e_o,
    output logic             flush_d_o,
    output logic             flush_e_o,
    output logic [SEL_W-1:0] fwd_a_o,
    output logic [SEL_W-1:0] fwd_b_o,
    output logic             dec_byp_a_o,
    output logic             dec_byp_b_o,
    output logic [31:0]      stall_cnt_o,
    output logic [31:0]      flush_cnt_o
);

    inflight_t       entry_reg  [DEPTH];
    inflight_t       entry_next [DEPTH];
    inflight_t       dec_entry;
    logic [RA_W-1:0] ex_rs1_reg, ex_rs1_next;
    logic [RA_W-1:0] ex_rs2_reg, ex_rs2_next;
    logic            haz;
    logic            bubble;
    logic            rs1_live, rs2_live;
    logic [SEL_W-1:0] fwd_a, fwd_b;

    assign rs1_live = dec_use_rs1_i && (dec_rs1_i != '0);
    assign rs2_live = dec_use_rs2_i && (dec_rs2_i != '0);

    // A source is blocked by entry i only while that entry's data is still further down the pipe.
    always_comb begin
        haz = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_reg[i].valid && (int'(entry_reg[i].rdy) > i)) begin
                if (rs1_live && (entry_reg[i].rd == dec_rs1_i)) haz = 1'b1;
                if (rs2_live && (entry_reg[i].rd == dec_rs2_i)) haz = 1'b1;
            end
        end
        haz = haz && dec_valid_i;
    end

    assign dec_entry.valid = dec_valid_i && dec_wen_i && (dec_rd_i != '0);
    assign dec_entry.rd    = dec_entry.valid ? dec_rd_i : '0;
    assign dec_entry.rdy   = (dec_entry.valid && dec_load_i) ? RDY_W'(LOAD_LAT) : '0;

    assign bubble = redirect_i || haz;

    assign entry_next[0] = ex_busy_i ? entry_reg[0] : (bubble ? '0 : dec_entry);
    assign entry_next[1] = ex_busy_i ? '0 : entry_reg[0];

    generate
        for (genvar gi = 2; gi < DEPTH; gi++) begin : g_shift
            assign entry_next[gi] = entry_reg[gi-1];
        end
    endgenerate

    assign ex_rs1_next = ex_busy_i ? ex_rs1_reg :
                         (bubble || !dec_valid_i || !dec_use_rs1_i) ? '0 : dec_rs1_i;
    assign ex_rs2_next = ex_busy_i ? ex_rs2_reg :
                         (bubble || !dec_valid_i || !dec_use_rs2_i) ? '0 : dec_rs2_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) entry_reg[i] <= '0;
            ex_rs1_reg <= '0;
            ex_rs2_reg <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) entry_reg[i] <= entry_next[i];
            ex_rs1_reg <= ex_rs1_next;
            ex_rs2_reg <= ex_rs2_next;
        end
    end

    // Scan oldest to youngest so the youngest ready producer overrides.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        for (int k = DEPTH - 1; k >= 1; k--) begin
            if (entry_reg[k].valid && (int'(entry_reg[k].rdy) < k)) begin
                if ((ex_rs1_reg != '0) && (entry_reg[k].rd == ex_rs1_reg)) fwd_a = SEL_W'(k);
                if ((ex_rs2_reg != '0) && (entry_reg[k].rd == ex_rs2_reg)) fwd_b = SEL_W'(k);
            end
        end
    end

    // Outputs are forced low while reset is asserted, even with ex_busy_i high.
    assign stall_f_o   = rst && (ex_busy_i || (!redirect_i && haz));
    assign stall_d_o   = stall_f_o;
    assign stall_e_o   = rst && ex_busy_i;
    assign flush_d_o   = rst && !ex_busy_i && redirect_i;
    assign flush_e_o   = rst && !ex_busy_i && bubble;
    assign fwd_a_o     = rst ? fwd_a : '0;
    assign fwd_b_o     = rst ? fwd_b : '0;
    assign dec_byp_a_o = rst && entry_reg[DEPTH-1].valid && rs1_live
                         && (entry_reg[DEPTH-1].rd == dec_rs1_i);
    assign dec_byp_b_o = rst && entry_reg[DEPTH-1].valid && rs2_live
                         && (entry_reg[DEPTH-1].rd == dec_rs2_i);

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_cnt u_perf_cnt (
        .clk       (clk),
        .rst       (rst),
        .stall_inc (stall_d_o),
        .flush_inc (flush_d_o || flush_e_o),
        .stall_cnt (stall_cnt_o),
        .flush_cnt (flush_cnt_o)
    );
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule
